sys_array_c_writer: RTL and testbench
=====================================

Name: sys_array_c_writer

Overview:
- Writeback stage directly downstream of the systolic array.
- Consumes the skewed per-column result stream (out_c / out_c_valid) and registers it onto the C memory write port.
- Generates a per-column write address from a base address plus that column's row counter.
- Tracks completion of one output tile and signals done to the controller.

Parameters:
MESHROWS  4  mesh rows; with TILEROWS sets rows per output tile
MESHCOLS  4  mesh columns; one independent write lane each
TILEROWS  1  rows per tile; ROWS = MESHROWS*TILEROWS results per lane per tile
TILECOLS  1  words per lane per result beat
DATAWIDTH  32  width of each C word

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; begin a tile at c_base_addr
c_base_addr  in  16  row-0 write address, captured on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last lane's last write has issued
out_c  in  MESHCOLS x TILECOLS x DATAWIDTH  result words from the array
out_c_valid  in  MESHCOLS x 1  per-lane result valid
C  out  MESHCOLS x TILECOLS x DATAWIDTH  registered write data
C_col_write_addrs  out  MESHCOLS x 16  per-lane write address
C_write_valid  out  MESHCOLS x 1  per-lane write strobe

Behaviour:
- Reset (reset==0 at clock edge): state IDLE; busy=0, done=0, C_write_valid=0, C=0, C_col_write_addrs=0; all lane counters=0. Applies mid-tile; an in-flight tile is abandoned with no done.
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
- IDLE:
  - start=1 -> capture c_base_addr, clear counters, go to ACTIVE; busy=1 from the next cycle.
  - out_c_valid is ignored; no write is issued.
- ACTIVE, lane j:
  - out_c_valid[j]=1 and cnt[j]<ROWS -> next cycle: C_write_valid[j]=1, C[j]=out_c[j], C_col_write_addrs[j]=base+cnt[j] (16-bit, wraps mod 2^16); cnt[j] increments.
  - Otherwise C_write_valid[j]=0; C[j] and the address hold their last value.
  - Lanes are independent; skew between lanes of any length is tolerated.
  - Valid on a lane with cnt[j]==ROWS is dropped (no write, no count).
- All lanes reaching ROWS in the same cycle -> DRAIN. The final write strobe is visible during DRAIN.
- DRAIN -> DONE after 1 cycle; DONE asserts done=1 and busy=0, then -> IDLE.
- Latency: fixed 1 cycle from out_c_valid to C_write_valid; no backpressure (memory always accepts).
- start while busy (ACTIVE/DRAIN/DONE) is ignored. start in the same cycle as done is also ignored; the earliest accepted start is the cycle after done.
- Counter width is $clog2(ROWS+1); ROWS==1 is legal (ACTIVE lasts until each lane writes once).

Optional Feature:
- Macro: SYS_ARRAY_C_WRITER_ERR_EN.
- Defined: adds output err (1 bit, sticky, cleared only by reset). err sets the cycle after either:
  - out_c_valid[j]=1 while IDLE, or
  - out_c_valid[j]=1 on a lane with cnt[j]==ROWS.
  Data is dropped as in the base behaviour.
- Undefined: no err port; such beats are silently dropped.

Test Plan:
1. Reset low 2 cycles with out_c_valid all 1 -> all outputs 0, no writes, busy=0.
2. MESHCOLS=4, ROWS=4; start with base 0x0100; all lanes valid 4 consecutive cycles, data 0xA0+j*16+row -> each lane writes addrs 0x0100..0x0103 with matching data, 1-cycle latency; done pulses exactly once, 2 cycles after the last valid.
3. Skew: lane j valid starts j cycles after lane 0 -> lane-by-lane addresses 0x0100..0x0103; done only after lane 3's 4th write.
4. Base 0xFFFE, ROWS=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. Extra 5th valid on lane 0 and a second start mid-tile -> no 5th write, base unchanged, single done; with SYS_ARRAY_C_WRITER_ERR_EN, err=1 and held.
6. Reset pulled low after 2 of 4 rows -> no done; a new start with base 0x0200 writes 0x0200..0x0203 correctly.

Source files
------------

// File: rtl/sys_array_c_writer_if.sv
// Bus bundle between the systolic array, the C writer and the C memory port.
// err exists only when SYS_ARRAY_C_WRITER_ERR_EN is defined.
interface sys_array_c_writer_if #(
   parameter int MESHCOLS  = 4,
   parameter int TILECOLS  = 1,
   parameter int DATAWIDTH = 32
);
   logic                                             start;
   logic [15:0]                                      c_base_addr;
   logic                                             busy;
   logic                                             done;
   logic [MESHCOLS-1:0][TILECOLS-1:0][DATAWIDTH-1:0] out_c;
   logic [MESHCOLS-1:0]                              out_c_valid;
   logic [MESHCOLS-1:0][TILECOLS-1:0][DATAWIDTH-1:0] C;
   logic [MESHCOLS-1:0][15:0]                        C_col_write_addrs;
   logic [MESHCOLS-1:0]                              C_write_valid;
`ifdef SYS_ARRAY_C_WRITER_ERR_EN
   logic                                             err;

   modport master (
      output start, c_base_addr, out_c, out_c_valid,
      input  busy, done, C, C_col_write_addrs, C_write_valid, err
   );
   modport slave (
      input  start, c_base_addr, out_c, out_c_valid,
      output busy, done, C, C_col_write_addrs, C_write_valid, err
   );
`else
   modport master (
      output start, c_base_addr, out_c, out_c_valid,
      input  busy, done, C, C_col_write_addrs, C_write_valid
   );
   modport slave (
      input  start, c_base_addr, out_c, out_c_valid,
      output busy, done, C, C_col_write_addrs, C_write_valid
   );
`endif
endinterface

// File: rtl/sys_array_c_writer.sv
// C writeback: registers per-lane array results onto the C write port, 1-cycle latency, no backpressure.
// Optional sticky err output for stray/overflow beats when SYS_ARRAY_C_WRITER_ERR_EN is defined.
module sys_array_c_writer #(
   parameter int MESHROWS  = 4,
   parameter int MESHCOLS  = 4,
   parameter int TILEROWS  = 1,
   parameter int TILECOLS  = 1,
   parameter int DATAWIDTH = 32
) (
   input logic                  clock,
   input logic                  reset,
   sys_array_c_writer_if.slave  bus
);
   localparam int ROWS = MESHROWS * TILEROWS;
   localparam int CW   = $clog2(ROWS + 1);
   localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   state_t                                           state_q;
   state_t                                           state_d;
   logic [15:0]                                      base_q;
   logic [MESHCOLS-1:0][CW-1:0]                      cnt_q;
   logic [MESHCOLS-1:0][CW-1:0]                      cnt_d;
   logic [MESHCOLS-1:0]                              lane_wr;
   logic [MESHCOLS-1:0]                              lane_full_d;
   logic                                             start_acc;
   logic [MESHCOLS-1:0][TILECOLS-1:0][DATAWIDTH-1:0] c_q;
   logic [MESHCOLS-1:0][15:0]                        addr_q;
   logic [MESHCOLS-1:0]                              wr_vld_q;

   // Lanes advance independently; a lane that already holds ROWS results drops further beats.
   always_comb begin
      lane_wr     = '0;
      cnt_d       = cnt_q;
      lane_full_d = '0;
      start_acc   = (state_q == IDLE) && bus.start;
      for (int j = 0; j < MESHCOLS; j++) begin
         lane_wr[j]     = (state_q == ACTIVE) && bus.out_c_valid[j] && (cnt_q[j] < ROWS_C);
         cnt_d[j]       = cnt_q[j] + CW'(lane_wr[j]);
         lane_full_d[j] = (cnt_d[j] == ROWS_C);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_acc) state_d = ACTIVE;
         ACTIVE:  if (&lane_full_d) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         base_q   <= '0;
         cnt_q    <= '0;
         c_q      <= '0;
         addr_q   <= '0;
         wr_vld_q <= '0;
      end else begin
         if (start_acc) begin
            base_q <= bus.c_base_addr;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
         for (int j = 0; j < MESHCOLS; j++) begin
            wr_vld_q[j] <= lane_wr[j];
            if (lane_wr[j]) begin
               c_q[j]    <= bus.out_c[j];
               addr_q[j] <= base_q + 16'(cnt_q[j]);
            end
         end
      end
   end

`ifdef SYS_ARRAY_C_WRITER_ERR_EN
   logic [MESHCOLS-1:0] err_hit;
   logic                err_q;

   always_comb begin
      err_hit = '0;
      for (int j = 0; j < MESHCOLS; j++) begin
         err_hit[j] = bus.out_c_valid[j] && ((state_q == IDLE) || (cnt_q[j] == ROWS_C));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (|err_hit) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`endif

   assign bus.busy              = (state_q == ACTIVE) || (state_q == DRAIN);
   assign bus.done              = (state_q == DONE);
   assign bus.C                 = c_q;
   assign bus.C_col_write_addrs = addr_q;
   assign bus.C_write_valid     = wr_vld_q;
endmodule

// File: tb/tb_sys_array_c_writer.sv
// Directed bench for sys_array_c_writer (4x4 mesh, ROWS=4); err checks are active when SYS_ARRAY_C_WRITER_ERR_EN is defined.
module tb_sys_array_c_writer;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   sys_array_c_writer_if #(.MESHCOLS(4), .TILECOLS(1), .DATAWIDTH(32)) bus ();

   sys_array_c_writer #(
      .MESHROWS (4),
      .MESHCOLS (4),
      .TILEROWS (1),
      .TILECOLS (1),
      .DATAWIDTH(32)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cyc();
      bus.out_c_valid = '0;
      cyc();
   endtask

   task automatic do_start(input logic [15:0] base, input string tag);
      bus.out_c_valid = '0;
      bus.start       = 1'b1;
      bus.c_base_addr = base;
      cyc();
      bus.start = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_wv"}, 32'(bus.C_write_valid), 32'd0);
   endtask

   // v: lanes presenting a beat; w: lanes expected to write; rows: row index per lane.
   task automatic beat(input logic [3:0] v, input logic [3:0] w, input int rows[4],
                       input logic [15:0] base, input string tag);
      logic [31:0] ed;
      logic [15:0] ea;
      for (int j = 0; j < 4; j++) begin
         bus.out_c[j][0] = 32'(32'hA0 + j * 16 + rows[j]);
      end
      bus.out_c_valid = v;
      cyc();
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("%s_wv%0d", tag, j), 32'(bus.C_write_valid[j]), 32'(w[j]));
         if (w[j]) begin
            ed = 32'(32'hA0 + j * 16 + rows[j]);
            ea = base + 16'(rows[j]);
            chk($sformatf("%s_dat%0d", tag, j), bus.C[j][0], ed);
            chk($sformatf("%s_adr%0d", tag, j), 32'(bus.C_col_write_addrs[j]), 32'(ea));
         end
      end
   endtask

   initial begin
      int rs[4];
      logic [3:0] vm;
      total = 0;
      bad   = 0;

      // reset with valids asserted
      reset           = 1'b0;
      bus.start       = 1'b0;
      bus.c_base_addr = '0;
      bus.out_c       = '0;
      bus.out_c_valid = '1;
      cyc();
      cyc();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_wv", 32'(bus.C_write_valid), 32'd0);
      chk("rst_c0", bus.C[0][0], 32'd0);
      chk("rst_c3", bus.C[3][0], 32'd0);
      chk("rst_adr0", 32'(bus.C_col_write_addrs[0]), 32'd0);
      chk("rst_adr3", 32'(bus.C_col_write_addrs[3]), 32'd0);
`ifdef SYS_ARRAY_C_WRITER_ERR_EN
      chk("rst_err", 32'(bus.err), 32'd0);
`endif
      bus.out_c_valid = '0;
      reset = 1'b1;
      cyc();

      // aligned tile, base 0x0100
      do_start(16'h0100, "al_start");
      for (int r = 0; r < 4; r++) begin
         rs = '{r, r, r, r};
         beat(4'hF, 4'hF, rs, 16'h0100, "al");
         chk("al_done_early", 32'(bus.done), 32'd0);
      end
      chk("al_drain_busy", 32'(bus.busy), 32'd1);
      idle_cyc();
      chk("al_done", 32'(bus.done), 32'd1);
      chk("al_done_busy", 32'(bus.busy), 32'd0);
      chk("al_done_wv", 32'(bus.C_write_valid), 32'd0);
      // start coinciding with done must be ignored
      bus.start       = 1'b1;
      bus.c_base_addr = 16'h0500;
      cyc();
      bus.start = 1'b0;
      chk("al_post_done", 32'(bus.done), 32'd0);
      chk("al_start_on_done_ign", 32'(bus.busy), 32'd0);
      idle_cyc();
      chk("al_idle_busy", 32'(bus.busy), 32'd0);

      // skewed tile: lane j starts j cycles after lane 0
      do_start(16'h0100, "sk_start");
      for (int k = 0; k < 7; k++) begin
         for (int j = 0; j < 4; j++) begin
            vm[j] = (j <= k) && (k <= j + 3);
            rs[j] = vm[j] ? (k - j) : 0;
         end
         beat(vm, vm, rs, 16'h0100, "sk");
         chk("sk_done_early", 32'(bus.done), 32'd0);
         chk("sk_busy", 32'(bus.busy), 32'd1);
      end
      idle_cyc();
      chk("sk_done", 32'(bus.done), 32'd1);
      idle_cyc();
      chk("sk_done_once", 32'(bus.done), 32'd0);

      // address wrap at 0xFFFE
      do_start(16'hFFFE, "wr_start");
      for (int r = 0; r < 4; r++) begin
         rs = '{r, r, r, r};
         beat(4'hF, 4'hF, rs, 16'hFFFE, "wrap");
      end
      chk("wrap_adr_last", 32'(bus.C_col_write_addrs[2]), 32'h0001);
      idle_cyc();
      chk("wrap_done", 32'(bus.done), 32'd1);
      idle_cyc();

      // extra beat on lane 0 and a second start mid-tile
      do_start(16'h0100, "ex_start");
      rs = '{0, 0, 0, 0};
      beat(4'h1, 4'h1, rs, 16'h0100, "ex0");
      rs = '{1, 0, 0, 0};
      beat(4'hF, 4'hF, rs, 16'h0100, "ex1");
      bus.start       = 1'b1;
      bus.c_base_addr = 16'h0300;
      rs = '{2, 1, 1, 1};
      beat(4'hF, 4'hF, rs, 16'h0100, "ex2");
      bus.start       = 1'b0;
      bus.c_base_addr = 16'h0000;
      rs = '{3, 2, 2, 2};
      beat(4'hF, 4'hF, rs, 16'h0100, "ex3");
`ifdef SYS_ARRAY_C_WRITER_ERR_EN
      chk("ex_err_clear", 32'(bus.err), 32'd0);
`endif
      rs = '{4, 3, 3, 3};
      beat(4'hF, 4'hE, rs, 16'h0100, "ex4");
      chk("ex_c0_hold", bus.C[0][0], 32'hA3);
      chk("ex_adr0_hold", 32'(bus.C_col_write_addrs[0]), 32'h0103);
      chk("ex_drain_busy", 32'(bus.busy), 32'd1);
`ifdef SYS_ARRAY_C_WRITER_ERR_EN
      chk("ex_err_set", 32'(bus.err), 32'd1);
`endif
      idle_cyc();
      chk("ex_done", 32'(bus.done), 32'd1);
      idle_cyc();
      chk("ex_done_once_a", 32'(bus.done), 32'd0);
      idle_cyc();
      chk("ex_done_once_b", 32'(bus.done), 32'd0);
      // valids while idle produce no write
      bus.out_c_valid = 4'hF;
      cyc();
      chk("idle_valid_wv", 32'(bus.C_write_valid), 32'd0);
      idle_cyc();
      chk("idle_valid_wv2", 32'(bus.C_write_valid), 32'd0);
`ifdef SYS_ARRAY_C_WRITER_ERR_EN
      chk("ex_err_held", 32'(bus.err), 32'd1);
`endif

      // reset mid-tile, then a fresh tile at 0x0200
      do_start(16'h0100, "rm_start");
      for (int r = 0; r < 2; r++) begin
         rs = '{r, r, r, r};
         beat(4'hF, 4'hF, rs, 16'h0100, "rm");
      end
      bus.out_c_valid = '0;
      reset = 1'b0;
      cyc();
      chk("rm_busy", 32'(bus.busy), 32'd0);
      chk("rm_done", 32'(bus.done), 32'd0);
      chk("rm_wv", 32'(bus.C_write_valid), 32'd0);
      chk("rm_adr0", 32'(bus.C_col_write_addrs[0]), 32'd0);
      chk("rm_c1", bus.C[1][0], 32'd0);
`ifdef SYS_ARRAY_C_WRITER_ERR_EN
      chk("rm_err", 32'(bus.err), 32'd0);
`endif
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle_cyc();
         chk("rm_no_done", 32'(bus.done), 32'd0);
      end
      do_start(16'h0200, "nt_start");
      for (int r = 0; r < 4; r++) begin
         rs = '{r, r, r, r};
         beat(4'hF, 4'hF, rs, 16'h0200, "nt");
      end
      idle_cyc();
      chk("nt_done", 32'(bus.done), 32'd1);
      idle_cyc();
      chk("nt_done_once", 32'(bus.done), 32'd0);
      chk("nt_idle_busy", 32'(bus.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
